pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/lu_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared types and constants for the pipeline hazard controller.
// Rev     : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 3;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTRY = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lu_detect.sv
`default_nettype none
// ============================================================================
// Module  : lu_detect
// Purpose : Combinational load-use comparator between the EX load and ID sources.
// Rev     : 1.0
// ============================================================================
module lu_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    output logic                  hazard
);

    assign hazard = ex_mem_read &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Pipeline stall/flush control with optional interrupt drain/entry
//           sequencing, enabled by macro PIPE_INT_SUPPORT_EN.
// Rev     : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int INT_DRAIN  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_branch_taken,
    input  logic                  int_req,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  int_ack,
    output logic                  int_active
);

    logic lu_hazard;
    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_flush_c;

    lu_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .hazard      (lu_hazard)
    );

`ifdef PIPE_INT_SUPPORT_EN
    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic               int_ack_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:   if (int_req && armed && !ex_branch_taken) state_nx = ST_DRAIN;
            ST_DRAIN: if (cnt == CNT_W'(1)) state_nx = ST_ENTRY;
            ST_ENTRY: state_nx = ST_RUN;
            default:  state_nx = ST_RUN;
        endcase
    end

    // Counter, re-arm flag and the registered acknowledge pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            armed     <= 1'b1;
            int_ack_r <= 1'b0;
        end else begin
            if (state == ST_RUN && state_nx == ST_DRAIN)
                cnt <= CNT_W'(INT_DRAIN);
            else if (state == ST_DRAIN)
                cnt <= cnt - CNT_W'(1);
            int_ack_r <= (state == ST_DRAIN) && (cnt == CNT_W'(1));
            if (state == ST_ENTRY)
                armed <= 1'b0;
            else if (!int_req)
                armed <= 1'b1;
        end
    end

    always_comb begin
        pc_hold_c     = 1'b0;
        if_id_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (lu_hazard) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_hold_c     = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = ex_branch_taken;
            end
            default: ;
        endcase
    end

    assign int_ack    = int_ack_r;
    assign int_active = (state != ST_RUN);
`else
    logic       unused_inputs;
    logic [3:0] unused_drain;

    assign unused_inputs = &{1'b0, clk, int_req};
    assign unused_drain  = 4'(INT_DRAIN);

    // Branch overrides load-use; there is no interrupt sequencing here
    always_comb begin
        pc_hold_c     = 1'b0;
        if_id_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        if (ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end else if (lu_hazard) begin
            pc_hold_c     = 1'b1;
            if_id_hold_c  = 1'b1;
            id_ex_flush_c = 1'b1;
        end
    end

    assign int_ack    = 1'b0;
    assign int_active = 1'b0;
`endif

    // Outputs are forced quiet while reset is asserted, whatever the inputs
    assign pc_hold     = reset_n & pc_hold_c;
    assign if_id_hold  = reset_n & if_id_hold_c;
    assign if_id_flush = reset_n & if_id_flush_c;
    assign id_ex_flush = reset_n & id_ex_flush_c;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Purpose : Directed scoreboard bench for pipe_hazard_ctrl (both builds).
// Rev     : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [2:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       ex_branch_taken = 1'b0, int_req = 1'b0;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_flush, int_ack, int_active;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(3), .INT_DRAIN(3)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_branch_taken (ex_branch_taken),
        .int_req         (int_req),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .int_ack         (int_ack),
        .int_active      (int_active)
    );

    // Expected vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_flush, int_ack, int_active}
    typedef struct {
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] LU  = 6'b110100;
    localparam logic [5:0] BR  = 6'b001100;
    localparam logic [5:0] DR  = 6'b101001;
    localparam logic [5:0] DRB = 6'b101101;
    localparam logic [5:0] ENT = 6'b000011;

    logic [5:0] obs;
    assign obs = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, int_ack, int_active};

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    end

    task automatic step(input logic rn, input logic mr, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic u1, input logic u2, input logic br,
                        input logic irq, input logic [5:0] ex, input string nm);
        exp_t e;
        reset_n = rn; ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_used = u1; id_rs2_used = u2; ex_branch_taken = br; int_req = irq;
        e.exp = ex; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        //   rn mr rd rs1 rs2 u1 u2 br irq exp  name
        step(0, 1, 2, 2, 0, 1, 0, 1, 1, Z,  "reset_outputs_zero");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,  "idle_after_reset");
        step(1, 1, 2, 2, 0, 1, 0, 0, 0, LU, "lu_rs1");
        step(1, 0, 2, 2, 0, 1, 0, 0, 0, Z,  "lu_bubble_done");
        step(1, 1, 2, 2, 0, 0, 0, 0, 0, Z,  "lu_rs1_unused");
        step(1, 1, 3, 2, 0, 1, 0, 0, 0, Z,  "lu_rd_differs");
        step(1, 1, 5, 1, 5, 0, 1, 0, 0, LU, "lu_rs2");
        step(1, 1, 5, 1, 5, 1, 0, 0, 0, Z,  "lu_rs2_unused");
        step(1, 0, 2, 2, 2, 1, 1, 0, 0, Z,  "no_load_match");
        step(1, 1, 2, 2, 0, 1, 0, 1, 0, BR, "lu_plus_branch");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, BR, "branch_only");
        step(1, 1, 0, 0, 0, 1, 1, 0, 0, LU, "lu_r0_both");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,  "idle");
`ifdef PIPE_INT_SUPPORT_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq_run_cycle");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, DR,  "drain_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, DR,  "drain_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, DR,  "drain_3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, ENT, "entry_ack");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "held_no_retrigger_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "held_no_retrigger_2");
        step(1, 1, 4, 4, 0, 1, 0, 0, 1, LU,  "held_lu_in_run");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   "irq_low_rearm");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq2_run_cycle");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, DRB, "drain_branch");
        step(1, 1, 4, 4, 0, 1, 0, 0, 1, DR,  "drain_lu_suppressed");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, DR,  "drain_irq_fall");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ENT, "entry_after_fall");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   "run_rearm");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, BR,  "irq_with_branch");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq_after_branch");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, DR,  "drain_after_branch");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "reset_mid_drain");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   "no_ack_after_reset_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   "no_ack_after_reset_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   "no_ack_after_reset_3");
`else
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq_ignored_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq_ignored_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq_ignored_3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, Z,   "irq_ignored_4");
        step(1, 1, 6, 0, 6, 0, 1, 0, 1, LU,  "irq_lu_unchanged");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, BR,  "irq_branch_unchanged");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   "irq_low");
`endif
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
